// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 configuration master: the register
// word table, the controller state encoding and the frame byte selector.
package wm8731_pkg;

   localparam int WORD_NUM = 10;

   // {reg[6:0], data[8:0]} words, element 0 is sent first
   localparam logic [0:WORD_NUM-1][15:0] WORD_TABLE = {
      16'h1E00,  // reset
      16'h0097,
      16'h0297,
      16'h0479,
      16'h0679,
      16'h0815,
      16'h0A00,
      16'h0C00,
      16'h0E42,  // master, I2S, 16-bit
      16'h1019   // USB mode, 32 kHz
   };

   typedef enum logic [2:0] {
      IDLE,
      START,
      BIT,
      ACK,
      STOP,
      GAP,
      DONE,
      ERR
   } state_t;

   // Byte idx of a frame: device address, then the word high and low bytes
   function automatic logic [7:0] frame_byte(input logic [7:0] dev_addr,
                                             input logic [15:0] word,
                                             input logic [1:0] idx);
      case (idx)
         2'd0:    return dev_addr;
         2'd1:    return word[15:8];
         default: return word[7:0];
      endcase
   endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit timebase: a tick every QUARTER clocks and a 2-bit phase that
// counts ticks, so each bit period is q0..q3 with the tick closing each quarter.
module i2c_tick_gen #(
   parameter int QUARTER = 30
) (
   input  logic       clk,
   input  logic       rst,
   output logic       tick,
   output logic [1:0] phase
);

   localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
   localparam logic [CW-1:0] LAST = CW'(QUARTER - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   // Divide clk down to quarter ticks and advance the quarter phase on each tick
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge values of the others.
      if (rst) begin
         cnt   <= '0;
         phase <= 2'd0;
      end else if (tick) begin
         cnt   <= '0;
         phase <= phase + 2'd1;
      end else begin
         cnt   <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/wm8731_i2c_init.sv
// Write-only I2C master that streams the WM8731 register table once after
// reset, retries NACKed words, and raises I2C_down (or o_error) when finished.
module wm8731_i2c_init
   import wm8731_pkg::*;
#(
   parameter int         QUARTER   = 30,
   parameter int         RETRY_MAX = 3,
   parameter logic [7:0] DEV_ADDR  = 8'h34
) (
   input  logic       clk,
   input  logic       rst,
   output logic       I2C_SCLK,
   inout  wire        I2C_SDAT,
   output logic       I2C_down,
   output logic       o_error,
   output logic [3:0] o_word_idx
);

   localparam int             RW         = $clog2(RETRY_MAX + 1);
   localparam logic [RW-1:0]  RETRY_LAST = RW'(RETRY_MAX);
   localparam logic [3:0]     LAST_WORD  = 4'(WORD_NUM - 1);

   logic          tick;
   logic [1:0]    phase;
   logic          bit_end;

   state_t        state, state_next;
   logic [2:0]    bit_cnt;
   logic [1:0]    byte_cnt;
   logic [RW-1:0] retry_cnt;
   logic [3:0]    word_idx;
   logic          nacked;

   logic          sda_meta, sda_sync, nack;
   logic          scl_next, sda_low_next;
   logic          scl_q, sda_low_q;

   logic [15:0]   cur_word;
   logic [7:0]    cur_byte;
   logic          cur_bit;

   i2c_tick_gen #(
      .QUARTER(QUARTER)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .phase(phase)
   );

   // The q3 tick closes one bit period; every state change happens here
   assign bit_end  = tick && (phase == 2'd3);
   assign nack     = sda_sync;
   assign cur_word = WORD_TABLE[word_idx];
   assign cur_byte = frame_byte(DEV_ADDR, cur_word, byte_cnt);
   assign cur_bit  = cur_byte[3'd7 - bit_cnt];

   // Bring the open-drain data line into the clk domain before sampling ACK
   always_ff @(posedge clk) begin
      if (rst) begin
         sda_meta <= 1'b1;
         sda_sync <= 1'b1;
      end else begin
         sda_meta <= I2C_SDAT;
         sda_sync <= sda_meta;
      end
   end

   // Controller state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic, evaluated only at bit-period boundaries
   always_comb begin
      // NOTE: the default assignment first keeps every path assigned, so no
      // latch is inferred.
      state_next = state;
      if (bit_end) begin
         case (state)
            IDLE:  state_next = START;
            START: state_next = BIT;
            BIT:   if (bit_cnt == 3'd7) state_next = ACK;
            ACK:   state_next = (nack || byte_cnt == 2'd2) ? STOP : BIT;
            STOP:  state_next = GAP;
            GAP: begin
               if (nacked)
                  state_next = (retry_cnt == RETRY_LAST) ? ERR : START;
               else
                  state_next = (word_idx == LAST_WORD) ? DONE : START;
            end
            default: state_next = state;
         endcase
      end
   end

   // Frame bookkeeping: bit/byte position, NACK memory, retries, word pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= 3'd0;
         byte_cnt  <= 2'd0;
         retry_cnt <= '0;
         word_idx  <= 4'd0;
         nacked    <= 1'b0;
      end else if (bit_end) begin
         case (state)
            START: begin
               bit_cnt  <= 3'd0;
               byte_cnt <= 2'd0;
               nacked   <= 1'b0;
            end
            BIT: bit_cnt <= bit_cnt + 3'd1;
            ACK: begin
               if (nack) begin
                  nacked    <= 1'b1;
                  retry_cnt <= retry_cnt + RW'(1);
               end else begin
                  byte_cnt  <= byte_cnt + 2'd1;
               end
            end
            GAP: begin
               if (!nacked) begin
                  retry_cnt <= '0;
                  if (word_idx != LAST_WORD) word_idx <= word_idx + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Bus levels per state and quarter; SCL is low in q0-q1 inside a frame
   always_comb begin
      scl_next     = 1'b1;
      sda_low_next = 1'b0;
      case (state)
         START: sda_low_next = phase[1];
         BIT: begin
            scl_next     = phase[1];
            sda_low_next = ~cur_bit;
         end
         ACK:  scl_next = phase[1];
         STOP: begin
            scl_next     = phase[1];
            sda_low_next = (phase != 2'd3);
         end
         default: ;
      endcase
   end

   // Register the bus drivers so both lines change cleanly on a clk edge
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_q     <= 1'b1;
         sda_low_q <= 1'b0;
      end else begin
         scl_q     <= scl_next;
         sda_low_q <= sda_low_next;
      end
   end

   // Sticky completion and abort flags, one clk after the terminal state
   always_ff @(posedge clk) begin
      if (rst) begin
         I2C_down <= 1'b0;
         o_error  <= 1'b0;
      end else begin
         if (state == DONE) I2C_down <= 1'b1;
         if (state == ERR)  o_error  <= 1'b1;
      end
   end

   assign I2C_SCLK   = scl_q;
   assign I2C_SDAT   = sda_low_q ? 1'b0 : 1'bz;
   assign o_word_idx = word_idx;

endmodule

// File: tb/tb_wm8731_i2c_init.sv
// Bench for wm8731_i2c_init: a bus-level slave/monitor decodes every byte and
// compares it against a scoreboard filled by a frame-level reference model.
module tb_wm8731_i2c_init;

   localparam int Q         = 10;
   localparam int BITP      = 4 * Q;
   localparam int RETRY_MAX = 3;

   typedef struct packed {
      logic [7:0] data;
      logic       nack;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl, down, err;
   logic [3:0] idx;
   logic       slave_low = 1'b0;
   wire        sda;

   pullup (sda);
   assign sda = slave_low ? 1'b0 : 1'bz;

   wm8731_i2c_init #(
      .QUARTER  (Q),
      .RETRY_MAX(RETRY_MAX),
      .DEV_ADDR (8'h34)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .I2C_SCLK  (scl),
      .I2C_SDAT  (sda),
      .I2C_down  (down),
      .o_error   (err),
      .o_word_idx(idx)
   );

   always #5 clk = ~clk;

   int   checks = 0, errors = 0;
   int   starts, stops, viol, bytes_seen;
   exp_t sb[$];
   int   plan [10][RETRY_MAX];  // byte index NACKed on that attempt, -1 = ACK all

   logic [15:0] table_words [10] = '{16'h1E00, 16'h0097, 16'h0297, 16'h0479, 16'h0679,
                                     16'h0815, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1019};

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int w, input int b);
      logic [15:0] t;
      t = table_words[w];
      if (b == 0)      return 8'h34;
      else if (b == 1) return t[15:8];
      else             return t[7:0];
   endfunction

   // Frame-level model: walks words and attempts, queues the bytes the slave
   // will see, and counts bit periods. A NACKed frame stops right after the
   // refused byte: START + 9 bits per byte sent + STOP + GAP.
   task automatic model_run(output int periods, output int frames, output bit fails);
      periods = 1;
      frames  = 0;
      fails   = 0;
      for (int w = 0; w < 10; w++) begin
         bit sent;
         sent = 0;
         for (int a = 0; a < RETRY_MAX && !sent; a++) begin
            int nb;
            nb = plan[w][a];
            frames++;
            for (int b = 0; b < 3; b++) begin
               exp_t e;
               if (nb >= 0 && b > nb) break;
               e.data = exp_byte(w, b);
               e.nack = (b == nb);
               sb.push_back(e);
            end
            if (nb < 0) begin
               periods += 30;
               sent = 1;
            end else begin
               periods += 9 * (nb + 1) + 3;
            end
         end
         if (!sent) begin
            fails = 1;
            return;
         end
      end
   endtask

   task automatic clear_plan();
      for (int w = 0; w < 10; w++)
         for (int a = 0; a < RETRY_MAX; a++) plan[w][a] = -1;
   endtask

   // Hold reset, check the idle state, then release just after an edge
   task automatic start_run(input string tag);
      rst = 1'b1;
      sb.delete();
      starts = 0; stops = 0; viol = 0; bytes_seen = 0;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_rst_scl"},  scl,  1);
      check({tag, "_rst_sda"},  sda,  1);
      check({tag, "_rst_down"}, down, 0);
      check({tag, "_rst_err"},  err,  0);
      check({tag, "_rst_idx"},  idx,  0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Edge count (1 = first edge with rst low) at which down / err first read 1
   task automatic wait_outcome(input int limit, output int n_down, output int n_err);
      n_down = 0;
      n_err  = 0;
      for (int n = 1; n <= limit && n_down == 0 && n_err == 0; n++) begin
         @(posedge clk);
         #1;
         if (down) n_down = n;
         if (err)  n_err  = n;
      end
   endtask

   task automatic wait_bytes(input int n, input int limit, output bit ok);
      ok = 0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(posedge clk);
         #1;
         if (bytes_seen >= n) ok = 1;
      end
   endtask

   // Slave + monitor: decodes bits on SCL rise, ACKs per scoreboard entry,
   // detects START/STOP and measures SCL high time inside frames.
   initial begin : monitor
      logic       s, d, scl_q, sda_q, in_frame, hi_track, ack_pend, ack_act, cur_nack;
      int         bitn, hi_len;
      logic [7:0] shreg;
      exp_t       e;
      scl_q = 1; sda_q = 1; in_frame = 0; hi_track = 0; ack_pend = 0; ack_act = 0;
      cur_nack = 0; bitn = 0; hi_len = 0; shreg = 0;
      forever begin
         @(negedge clk);
         s = scl;
         d = sda;
         if (rst) begin
            slave_low = 0;
            in_frame = 0; hi_track = 0; ack_pend = 0; ack_act = 0; bitn = 0;
            scl_q = 1; sda_q = 1;
         end else begin
            if (s && scl_q && d != sda_q) begin
               if (!d) begin starts++; in_frame = 1; end
               else    begin stops++;  in_frame = 0; end
               bitn = 0; hi_track = 0; ack_pend = 0;
            end
            if (s && !scl_q) begin
               if (d != sda_q) viol++;
               if (in_frame) begin
                  hi_track = 1;
                  hi_len   = 1;
                  if (bitn < 8) begin
                     shreg = {shreg[6:0], d};
                     bitn++;
                     if (bitn == 8) begin
                        if (sb.size() == 0) begin
                           checks++;
                           errors++;
                           $display("FAIL byte_unexpected: got 0x%02h with nothing expected", shreg);
                           cur_nack = 1;
                        end else begin
                           e = sb.pop_front();
                           check("byte", shreg, e.data);
                           cur_nack = e.nack;
                        end
                        bytes_seen++;
                        ack_pend = 1;
                     end
                  end else begin
                     check("ack_slot_level", d, cur_nack);
                     bitn = 0;
                  end
               end
            end else if (s && scl_q && hi_track) begin
               hi_len++;
            end
            if (!s && scl_q) begin
               if (hi_track) begin
                  check("scl_high_time", hi_len, 2 * Q);
                  hi_track = 0;
               end
               if (ack_pend) begin
                  slave_low = !cur_nack;
                  ack_pend  = 0;
                  ack_act   = 1;
               end else if (ack_act) begin
                  slave_low = 0;
                  ack_act   = 0;
               end
            end
            scl_q = s;
            sda_q = d;
         end
      end
   end

   initial begin : stimulus
      int periods, frames, n_down, n_err, rw, rb, bad, dly;
      bit fails, ok;

      // A: every byte ACKed
      clear_plan();
      start_run("A");
      model_run(periods, frames, fails);
      wait_outcome(BITP * periods + 4 * BITP, n_down, n_err);
      check("A_down_cycle", n_down, BITP * periods + 1);
      check("A_down_cycle_nominal", n_down, BITP * 301 + 1);
      check("A_error", err, 0);
      check("A_word_idx", idx, 9);
      repeat (BITP) @(posedge clk);
      #1;
      check("A_idle_scl", scl, 1);
      check("A_idle_sda", sda, 1);
      check("A_sb_drained", sb.size(), 0);
      check("A_starts", starts, frames);
      check("A_stops", stops, frames);
      check("A_sda_move_at_scl_rise", viol, 0);

      // B: word 3 address NACKed once, plus one random single NACK elsewhere
      clear_plan();
      rw = (3 + $urandom_range(1, 9)) % 10;
      rb = $urandom_range(0, 2);
      plan[3][0]  = 0;
      plan[rw][0] = rb;
      start_run("B");
      model_run(periods, frames, fails);
      wait_outcome(BITP * periods + 4 * BITP, n_down, n_err);
      check("B_down_cycle", n_down, BITP * periods + 1);
      check("B_error", err, 0);
      check("B_sb_drained", sb.size(), 0);
      check("B_starts", starts, frames);
      check("B_stops", stops, frames);

      // C: word 5 NACKed on every attempt at a random byte
      clear_plan();
      for (int a = 0; a < RETRY_MAX; a++) plan[5][a] = $urandom_range(0, 2);
      start_run("C");
      model_run(periods, frames, fails);
      check("C_model_aborts", fails, 1);
      wait_outcome(BITP * periods + 4 * BITP, n_down, n_err);
      check("C_error_cycle", n_err, BITP * periods + 1);
      check("C_down_low", n_down, 0);
      bad = 0;
      for (int i = 0; i < 5 * BITP; i++) begin
         @(posedge clk);
         #1;
         if (scl !== 1'b1 || sda !== 1'b1 || down !== 1'b0 || err !== 1'b1) bad++;
      end
      check("C_terminal_idle", bad, 0);
      check("C_word_idx", idx, 5);
      check("C_sb_drained", sb.size(), 0);
      check("C_starts", starts, frames);
      check("C_stops", stops, frames);

      // D: reset pulse inside word 6's first data byte
      clear_plan();
      start_run("D");
      model_run(periods, frames, fails);
      wait_bytes(19, 25 * 30 * BITP, ok);
      check("D_reached_word6", ok, 1);
      check("D_word_idx_before", idx, 6);
      dly = $urandom_range(7 * Q, 30 * Q);
      repeat (dly) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("D_scl_after_rst", scl, 1);
      check("D_sda_after_rst", sda, 1);
      check("D_idx_after_rst", idx, 0);
      sb.delete();
      bytes_seen = 0;
      for (int b = 0; b < 3; b++) begin
         exp_t e;
         e.data = exp_byte(0, b);
         e.nack = 1'b0;
         sb.push_back(e);
      end
      rst = 1'b0;
      wait_bytes(3, 32 * BITP, ok);
      check("D_restart_frame", ok, 1);
      check("D_sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
